// File: rtl/subword_data_ram_if.sv
// Request/response bundle for subword_data_ram.
// The master drives requests; the slave (the RAM) returns results.
interface subword_data_ram_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int NB_ADDR   = 32
);
    localparam int DW = NB_COL * COL_WIDTH;

    logic               ena;
    logic               req_valid;
    logic               req_we;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [NB_ADDR-1:0] addra;
    logic [DW-1:0]      dina;
    logic [DW-1:0]      douta;
    logic               rd_valid;
    logic               wr_ack;
    logic               misalign;
    logic [7:0]         err_cnt;

    modport master (
        output ena, req_valid, req_we, req_size, req_unsigned, addra, dina,
        input  douta, rd_valid, wr_ack, misalign, err_cnt
    );

    modport slave (
        input  ena, req_valid, req_we, req_size, req_unsigned, addra, dina,
        output douta, rd_valid, wr_ack, misalign, err_cnt
    );
endinterface

// File: rtl/subword_data_ram.sv
// Byte-addressed data RAM with byte/half/word loads and stores.
// Loads are right-justified and sign/zero extended; misaligned or reserved
// requests are rejected and counted. Fully pipelined, one request per cycle.
module subword_data_ram #(
    parameter int    NB_COL     = 4,
    parameter int    COL_WIDTH  = 8,
    parameter int    RAM_DEPTH  = 1024,
    parameter int    NB_ADDR    = 32,
    parameter string INIT_FILE  = "",
    parameter string WRITE_MODE = "READ_FIRST",
    parameter int    OUT_REG    = 0
) (
    input  logic              clka,
    input  logic              rsta,
    subword_data_ram_if.slave bus
);
    localparam int DW  = NB_COL * COL_WIDTH;
    localparam int LSB = $clog2(NB_COL);
    localparam int AW  = $clog2(RAM_DEPTH);

    localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

    typedef enum logic [1:0] {
        K_RD  = 2'd0,
        K_WR  = 2'd1,
        K_MIS = 2'd2
    } kind_e;

    typedef logic [DW-1:0] mem_t [RAM_DEPTH];

    // Power-up content: zeros.
    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < RAM_DEPTH; i++) m[i] = '0;
        return m;
    endfunction

    mem_t mem = mem_init();

    // ------------------------------------------------------------------
    // Request decode (accepting edge)
    // ------------------------------------------------------------------
    logic              acc;
    logic              mis;
    logic              we_ok;
    logic [LSB-1:0]    off;
    logic [AW-1:0]     widx;
    logic [NB_COL-1:0] be;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     wmask;
    logic              unused_addr;

    // Bits above the word index are ignored so addresses wrap.
    assign unused_addr = ^bus.addra;

    // Decode alignment, lane enables and lane-positioned store data.
    always_comb begin
        off   = bus.addra[LSB-1:0];
        widx  = bus.addra[LSB +: AW];
        acc   = bus.ena & bus.req_valid & ~rsta;
        mis   = 1'b0;
        be    = '1;
        case (bus.req_size)
            2'd0: be  = NB_COL'(1) << off;
            2'd1: begin
                be  = NB_COL'(3) << off;
                mis = bus.addra[0];
            end
            2'd2: mis = (off != '0);
            default: mis = 1'b1;
        endcase
        we_ok = acc & bus.req_we & ~mis;
        // Shifting places the low bytes of dina at the addressed lane;
        // lanes outside be are never written, so the spill is harmless.
        wdata = bus.dina << (int'(off) * COL_WIDTH);
        for (int i = 0; i < NB_COL; i++) begin
            wmask[i*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{be[i]}};
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte-lane writes, registered read of the whole word
    // ------------------------------------------------------------------
    logic [DW-1:0] rd_word_q;

    // Read-before-write on the same edge gives the old word for stores.
    always_ff @(posedge clka) begin
        if (acc) rd_word_q <= mem[widx];
        if (we_ok) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (be[i]) mem[widx][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: request attributes travelling alongside the read word
    // ------------------------------------------------------------------
    logic           s1_vld_q,   s1_vld_d;
    kind_e          s1_kind_q,  s1_kind_d;
    logic [1:0]     s1_size_q,  s1_size_d;
    logic           s1_uns_q,   s1_uns_d;
    logic [LSB-1:0] s1_off_q,   s1_off_d;
    logic [DW-1:0]  s1_mask_q,  s1_mask_d;
    logic [DW-1:0]  s1_wdata_q, s1_wdata_d;

    // Classify the accepted request and capture what the result path needs.
    always_comb begin
        s1_vld_d   = acc;
        s1_kind_d  = mis ? K_MIS : (bus.req_we ? K_WR : K_RD);
        s1_size_d  = bus.req_size;
        s1_uns_d   = bus.req_unsigned;
        s1_off_d   = off;
        s1_mask_d  = wmask;
        s1_wdata_d = wdata;
    end

    // Only the valid bit needs reset; payload is qualified by it.
    always_ff @(posedge clka) begin
        if (rsta) s1_vld_q <= 1'b0;
        else      s1_vld_q <= s1_vld_d;
        s1_kind_q  <= s1_kind_d;
        s1_size_q  <= s1_size_d;
        s1_uns_q   <= s1_uns_d;
        s1_off_q   <= s1_off_d;
        s1_mask_q  <= s1_mask_d;
        s1_wdata_q <= s1_wdata_d;
    end

    // ------------------------------------------------------------------
    // Result formation
    // ------------------------------------------------------------------
    logic          res_vld;
    logic          res_upd;
    kind_e         res_kind;
    logic [DW-1:0] res_data;
    int unsigned   sh;
    logic [DW-1:0] field;
    logic [DW-1:0] fmask;
    logic          sign;
    logic [DW-1:0] ext;
    logic [DW-1:0] merged;

    // Right-justify and extend loads; pick the store echo by write mode.
    always_comb begin
        sh    = int'(s1_off_q) * COL_WIDTH;
        field = rd_word_q >> sh;
        fmask = '1;
        sign  = field[DW-1];
        case (s1_size_q)
            2'd0: begin
                fmask = {{(DW-COL_WIDTH){1'b0}}, {COL_WIDTH{1'b1}}};
                sign  = field[COL_WIDTH-1];
            end
            2'd1: begin
                fmask = {{(DW-2*COL_WIDTH){1'b0}}, {(2*COL_WIDTH){1'b1}}};
                sign  = field[2*COL_WIDTH-1];
            end
            default: ;
        endcase
        ext = field & fmask;
        if (!s1_uns_q && sign) ext = ext | ~fmask;

        merged   = (rd_word_q & ~s1_mask_q) | (s1_wdata_q & s1_mask_q);
        res_vld  = s1_vld_q;
        res_kind = s1_kind_q;
        res_data = ext;
        res_upd  = 1'b0;
        case (s1_kind_q)
            K_RD: res_upd = s1_vld_q;
            K_WR: begin
                res_data = MODE_WF ? merged : rd_word_q;
                res_upd  = s1_vld_q & ~MODE_NC;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    logic          f_vld;
    logic          f_upd;
    kind_e         f_kind;
    logic [DW-1:0] f_data;

    if (OUT_REG != 0) begin : g_oreg
        logic          o_vld_q,  o_vld_d;
        logic          o_upd_q,  o_upd_d;
        kind_e         o_kind_q, o_kind_d;
        logic [DW-1:0] o_data_q, o_data_d;

        // Delay the formed result by one cycle.
        always_comb begin
            o_vld_d  = res_vld;
            o_upd_d  = res_upd;
            o_kind_d = res_kind;
            o_data_d = res_data;
        end

        // Valid and update flags are cleared so reset drops in-flight results.
        always_ff @(posedge clka) begin
            if (rsta) begin
                o_vld_q <= 1'b0;
                o_upd_q <= 1'b0;
            end else begin
                o_vld_q <= o_vld_d;
                o_upd_q <= o_upd_d;
            end
            o_kind_q <= o_kind_d;
            o_data_q <= o_data_d;
        end

        assign f_vld  = o_vld_q;
        assign f_upd  = o_upd_q;
        assign f_kind = o_kind_q;
        assign f_data = o_data_q;
    end else begin : g_noreg
        assign f_vld  = res_vld;
        assign f_upd  = res_upd;
        assign f_kind = res_kind;
        assign f_data = res_data;
    end

    // ------------------------------------------------------------------
    // Output hold register and reject counter
    // ------------------------------------------------------------------
    logic [DW-1:0] douta_q, douta_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // douta shows a new result in its own cycle and otherwise holds;
    // the counter shows the incremented value in the misalign cycle.
    always_comb begin
        douta_d   = f_upd ? f_data : douta_q;
        err_cnt_d = err_cnt_q;
        if (f_vld && f_kind == K_MIS && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Remember what is shown so it can be held across idle cycles.
    always_ff @(posedge clka) begin
        if (rsta) begin
            douta_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            douta_q   <= douta_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.douta    = douta_d;
    assign bus.rd_valid = f_vld & (f_kind == K_RD);
    assign bus.wr_ack   = f_vld & (f_kind == K_WR);
    assign bus.misalign = f_vld & (f_kind == K_MIS);
    assign bus.err_cnt  = err_cnt_d;
endmodule

// File: tb/tb_subword_data_ram.sv
// Scoreboard bench: four RAM configurations share one stimulus stream;
// each has its own expected-response queue and monitor.
// dut0: OUT_REG=0 READ_FIRST, dut1: OUT_REG=0 WRITE_FIRST,
// dut2: OUT_REG=0 NO_CHANGE,  dut3: OUT_REG=1 READ_FIRST.
module tb_subword_data_ram;
    localparam int ND = 4;
    localparam logic [1:0] KRD = 2'd0, KWR = 2'd1, KMIS = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        int          due;
        logic [7:0]  err;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rsta;
    logic        ena_s, req_valid_s, req_we_s, req_uns_s;
    logic [1:0]  req_size_s;
    logic [31:0] addr_s, din_s;

    logic [31:0]   douta_w [ND];
    logic [7:0]    err_w   [ND];
    logic [ND-1:0] rv_w, wa_w, ms_w;

    exp_t        exp_q  [ND][$];
    logic [31:0] last_m [ND];
    logic [7:0]  err_m  [ND];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input int d, input int tag, input string what,
                            input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL dut%0d tag%0d %s: got %h, expected %h", d, tag, what, act, req);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam string WM = (g == 1) ? "WRITE_FIRST" : (g == 2) ? "NO_CHANGE" : "READ_FIRST";
        localparam int    OR = (g == 3) ? 1 : 0;

        subword_data_ram_if #(.NB_COL(4), .COL_WIDTH(8), .NB_ADDR(32)) bus ();

        exp_t       e;
        logic [1:0] ak;

        assign bus.ena          = ena_s;
        assign bus.req_valid    = req_valid_s;
        assign bus.req_we       = req_we_s;
        assign bus.req_size     = req_size_s;
        assign bus.req_unsigned = req_uns_s;
        assign bus.addra        = addr_s;
        assign bus.dina         = din_s;
        assign douta_w[g]       = bus.douta;
        assign err_w[g]         = bus.err_cnt;
        assign rv_w[g]          = bus.rd_valid;
        assign wa_w[g]          = bus.wr_ack;
        assign ms_w[g]          = bus.misalign;

        subword_data_ram #(
            .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(1024), .NB_ADDR(32),
            .INIT_FILE(""), .WRITE_MODE(WM), .OUT_REG(OR)
        ) dut (
            .clka(clk),
            .rsta(rsta),
            .bus (bus.slave)
        );

        always @(negedge clk) begin
            if (started && (rv_w[g] | wa_w[g] | ms_w[g])) begin
                if (int'(rv_w[g]) + int'(wa_w[g]) + int'(ms_w[g]) > 1) ak = 2'd3;
                else if (rv_w[g]) ak = KRD;
                else if (wa_w[g]) ak = KWR;
                else              ak = KMIS;
                if (exp_q[g].size() == 0) begin
                    check_eq(g, -1, "unexpected pulse", {29'd0, rv_w[g], wa_w[g], ms_w[g]}, 32'd0);
                end else begin
                    e = exp_q[g].pop_front();
                    check_eq(g, e.tag, "pulse kind", {30'd0, ak}, {30'd0, e.kind});
                    check_eq(g, e.tag, "pulse cycle", 32'(cyc), 32'(e.due));
                    check_eq(g, e.tag, "err_cnt", {24'd0, err_w[g]}, {24'd0, e.err});
                    check_eq(g, e.tag, "douta", douta_w[g], e.data);
                end
            end
        end
    end

    // Drive one request for one edge; push per-configuration expectations.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] kind, input logic [31:0] rdv,
                         input logic [31:0] oldw, input logic [31:0] neww,
                         input bit [ND-1:0] dmask, input int tag);
        exp_t x;
        int   acc_cyc;
        ena_s = 1'b1; req_valid_s = 1'b1; req_we_s = we;
        req_size_s = sz; req_uns_s = uns; addr_s = a; din_s = d;
        acc_cyc = cyc + 1;
        for (int g = 0; g < ND; g++) begin
            if (dmask[g]) begin
                x.kind = kind;
                x.tag  = tag;
                x.due  = acc_cyc + ((g == 3) ? 1 : 0);
                if (kind == KRD)      x.data = rdv;
                else if (kind == KWR) x.data = (g == 1) ? neww : (g == 2) ? last_m[g] : oldw;
                else                  x.data = last_m[g];
                if (kind == KMIS && err_m[g] != 8'hFF) err_m[g] = err_m[g] + 8'd1;
                last_m[g] = x.data;
                x.err = err_m[g];
                exp_q[g].push_back(x);
            end
        end
        @(negedge clk);
        req_valid_s = 1'b0;
        ena_s = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a,
                      input logic [31:0] rdv, input int tag);
        issue(1'b0, sz, uns, a, 32'h0, KRD, rdv, 32'h0, 32'h0, 4'hF, tag);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] oldw, input logic [31:0] neww, input int tag);
        issue(1'b1, sz, 1'b0, a, d, KWR, 32'h0, oldw, neww, 4'hF, tag);
    endtask

    task automatic bad(input bit we, input logic [1:0] sz, input logic [31:0] a, input int tag);
        issue(we, sz, 1'b0, a, 32'h55555555, KMIS, 32'h0, 32'h0, 32'h0, 4'hF, tag);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int g = 0; g < ND; g++) check_eq(g, -2, "pending responses", 32'(exp_q[g].size()), 32'd0);
    endtask

    task automatic clear_model();
        for (int g = 0; g < ND; g++) begin
            last_m[g] = 32'h0;
            err_m[g]  = 8'h0;
        end
    endtask

    task automatic post_reset_checks(input int tag);
        for (int g = 0; g < ND; g++) begin
            check_eq(g, tag, "douta after reset", douta_w[g], 32'h0);
            check_eq(g, tag, "err_cnt after reset", {24'd0, err_w[g]}, 32'h0);
            check_eq(g, tag, "pulses after reset", {29'd0, rv_w[g], wa_w[g], ms_w[g]}, 32'h0);
        end
    endtask

    task automatic hold_checks(input int tag);
        for (int g = 0; g < ND; g++) begin
            check_eq(g, tag, "douta hold", douta_w[g], last_m[g]);
            check_eq(g, tag, "err_cnt hold", {24'd0, err_w[g]}, {24'd0, err_m[g]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rsta = 1'b1; ena_s = 1'b0; req_valid_s = 1'b0; req_we_s = 1'b0;
        req_size_s = 2'd0; req_uns_s = 1'b0; addr_s = 32'h0; din_s = 32'h0;
        clear_model();
        repeat (3) @(negedge clk);
        post_reset_checks(0);
        rsta = 1'b0;
        started = 1'b1;

        // Store word then byte loads of it
        st(2'd2, 32'h10, 32'h8899AABB, 32'h0, 32'h8899AABB, 1);
        ld(2'd0, 1'b0, 32'h11, 32'hFFFFFFAA, 2);
        ld(2'd0, 1'b1, 32'h13, 32'h00000088, 3);
        // Word store, half store next cycle, then loads
        st(2'd2, 32'h10, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 4);
        st(2'd1, 32'h12, 32'hFFFF1234, 32'h8899AABB, 32'h1234AABB, 5);
        ld(2'd2, 1'b0, 32'h10, 32'h1234AABB, 6);
        ld(2'd1, 1'b1, 32'h12, 32'h00001234, 7);
        ld(2'd1, 1'b0, 32'h10, 32'hFFFFAABB, 8);
        ld(2'd0, 1'b0, 32'h10, 32'hFFFFFFBB, 9);
        ld(2'd0, 1'b1, 32'h11, 32'h000000AA, 10);
        // Rejected requests
        bad(1'b0, 2'd1, 32'h11, 11);
        bad(1'b1, 2'd2, 32'h22, 12);
        bad(1'b0, 2'd3, 32'h00, 13);
        ld(2'd2, 1'b0, 32'h20, 32'h00000000, 14);
        // Store echo per write mode
        ld(2'd2, 1'b0, 32'h10, 32'h1234AABB, 15);
        st(2'd2, 32'h20, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 16);
        ld(2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 17);
        st(2'd1, 32'h22, 32'h00008001, 32'hDEADBEEF, 32'h8001BEEF, 18);
        ld(2'd1, 1'b0, 32'h22, 32'hFFFF8001, 19);
        ld(2'd1, 1'b1, 32'h22, 32'h00008001, 20);
        ld(2'd0, 1'b0, 32'h23, 32'hFFFFFF80, 21);
        ld(2'd0, 1'b1, 32'h20, 32'h000000EF, 22);
        ld(2'd0, 1'b0, 32'h21, 32'hFFFFFFBE, 23);
        repeat (3) @(negedge clk);
        drain();
        hold_checks(24);

        // ena=0 request: nothing happens
        ena_s = 1'b0; req_valid_s = 1'b1; req_we_s = 1'b1; req_size_s = 2'd2;
        addr_s = 32'h30; din_s = 32'h22222222;
        @(negedge clk);
        req_valid_s = 1'b0;
        // Store on the same edge as reset: ignored
        rsta = 1'b1; ena_s = 1'b1; req_valid_s = 1'b1; req_we_s = 1'b1;
        req_size_s = 2'd2; addr_s = 32'h34; din_s = 32'h11111111;
        @(negedge clk);
        rsta = 1'b0; req_valid_s = 1'b0; ena_s = 1'b0;
        clear_model();
        post_reset_checks(25);
        ld(2'd2, 1'b0, 32'h30, 32'h00000000, 26);
        ld(2'd2, 1'b0, 32'h34, 32'h00000000, 27);
        st(2'd0, 32'h31, 32'h123456A5, 32'h0, 32'h0000A500, 28);
        ld(2'd0, 1'b1, 32'h31, 32'h000000A5, 29);
        ld(2'd2, 1'b0, 32'h30, 32'h0000A500, 30);
        ld(2'd0, 1'b0, 32'h31, 32'hFFFFFFA5, 31);
        // Address wrap
        st(2'd2, 32'h1000, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32);
        ld(2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 33);
        ld(2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 34);
        drain();

        // Reset one cycle after a load: the registered-output copy never answers
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, KRD, 32'h1234AABB, 32'h0, 32'h0, 4'b0111, 35);
        rsta = 1'b1;
        @(negedge clk);
        rsta = 1'b0;
        clear_model();
        post_reset_checks(36);
        repeat (4) @(negedge clk);
        drain();
        hold_checks(37);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) bad(1'b0, 2'd3, 32'h0, 100);
            else            bad(1'b1, 2'd2, 32'h1, 101);
        end
        drain();
        for (int g = 0; g < ND; g++) check_eq(g, 102, "err_cnt saturated", {24'd0, err_w[g]}, 32'd255);
        hold_checks(103);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
